// File: rtl/rr_buffer_arbiter.sv
// Round-robin arbiter feeding a single-entry registered output buffer.
// N valid/ready requesters share one downstream valid/ready channel.
module rr_buffer_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_src,
  input  logic            out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef logic [SW:0] ext_t;

  state_t         state;
  state_t         state_nxt;
  logic [SW-1:0]  ptr;
  logic [SW-1:0]  gnt_idx;
  logic           found;
  logic [N-1:0]   grant;
  logic           load;
  logic           fire;
  logic           drain;
  ext_t           idx;

  // Rotating priority scan starting at ptr; independent of req_ready.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + ext_t'(k);
      if (idx >= ext_t'(N)) begin
        idx = idx - ext_t'(N);
      end
      if (!found && req_valid[idx[SW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[SW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) begin
      grant = N'(1) << gnt_idx;
    end
  end

  assign out_valid = (state == FULL);
  assign load      = !rst && (!out_valid || out_ready);
  assign fire      = load && found;
  assign drain     = out_valid && out_ready;
  assign req_ready = load ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (fire) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (drain && !fire) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_src  <= '0;
    end else if (fire) begin
      out_data <= req_data[gnt_idx*W +: W];
      out_src  <= gnt_idx;
    end
  end

  // Pointer moves just past the winner, wrapping N-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (fire) begin
      if (gnt_idx == SW'(N - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= gnt_idx + SW'(1);
      end
    end
  end

endmodule
